// File: rtl/blob_bbox_extractor_pkg.sv
// Shared constants for the blob bounding-box extractor: default widths, FSM encoding, empty-entry fill values.
package blob_bbox_extractor_pkg;

   localparam int DEF_NUM_LABELS  = 64;
   localparam int DEF_LABEL_WIDTH = 8;
   localparam int DEF_COORD_WIDTH = 10;
   localparam int DEF_COUNT_WIDTH = 20;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // An empty entry has min fields all ones and max fields all zeros, so the first pixel wins both compares.
   localparam logic EMPTY_MIN_FILL = 1'b1;
   localparam logic EMPTY_MAX_FILL = 1'b0;

endpackage

// File: rtl/blob_bbox_extractor_bbox_merge.sv
// Combinational merge of one pixel into a bbox entry; zero latency.
// Pixel count saturates at all ones.
module bbox_merge #(
   parameter int COORD_WIDTH = 10,
   parameter int COUNT_WIDTH = 20
) (
   input  logic [COORD_WIDTH-1:0] x,
   input  logic [COORD_WIDTH-1:0] y,
   input  logic [COORD_WIDTH-1:0] old_x_min,
   input  logic [COORD_WIDTH-1:0] old_x_max,
   input  logic [COORD_WIDTH-1:0] old_y_min,
   input  logic [COORD_WIDTH-1:0] old_y_max,
   input  logic [COUNT_WIDTH-1:0] old_count,
   output logic [COORD_WIDTH-1:0] new_x_min,
   output logic [COORD_WIDTH-1:0] new_x_max,
   output logic [COORD_WIDTH-1:0] new_y_min,
   output logic [COORD_WIDTH-1:0] new_y_max,
   output logic [COUNT_WIDTH-1:0] new_count
);

   always_comb begin
      new_x_min = (x < old_x_min) ? x : old_x_min;
      new_x_max = (x > old_x_max) ? x : old_x_max;
      new_y_min = (y < old_y_min) ? y : old_y_min;
      new_y_max = (y > old_y_max) ? y : old_y_max;
      new_count = (old_count == {COUNT_WIDTH{1'b1}}) ? old_count : old_count + COUNT_WIDTH'(1);
   end

endmodule

// File: rtl/blob_bbox_extractor.sv
// Per-label bbox/count accumulation over a frame; single-cycle read-modify-write per pixel, records one cycle after scan.
// Drain holds each record until out_ready; pixels arriving while busy are discarded and flagged in dropped.
module blob_bbox_extractor
   import blob_bbox_extractor_pkg::*;
#(
   parameter int NUM_LABELS  = DEF_NUM_LABELS,
   parameter int LABEL_WIDTH = DEF_LABEL_WIDTH,
   parameter int COORD_WIDTH = DEF_COORD_WIDTH,
   parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   en,
   input  logic                   frame_end,
   input  logic [COORD_WIDTH-1:0] x,
   input  logic [COORD_WIDTH-1:0] y,
   input  logic [LABEL_WIDTH-1:0] label,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LABEL_WIDTH-1:0] out_label,
   output logic [COORD_WIDTH-1:0] out_x_min,
   output logic [COORD_WIDTH-1:0] out_x_max,
   output logic [COORD_WIDTH-1:0] out_y_min,
   output logic [COORD_WIDTH-1:0] out_y_max,
   output logic [COUNT_WIDTH-1:0] out_count,
   output logic                   frame_done,
   output logic                   busy,
   output logic                   dropped
);

   localparam int IDX_W = $clog2(NUM_LABELS);
   localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(NUM_LABELS - 1);
   localparam logic [LABEL_WIDTH:0] LABEL_LIMIT = (LABEL_WIDTH + 1)'(NUM_LABELS);

   typedef struct packed {
      logic [COORD_WIDTH-1:0] x_min;
      logic [COORD_WIDTH-1:0] x_max;
      logic [COORD_WIDTH-1:0] y_min;
      logic [COORD_WIDTH-1:0] y_max;
      logic [COUNT_WIDTH-1:0] count;
   } entry_t;

   localparam entry_t ENTRY_EMPTY = '{
      x_min: {COORD_WIDTH{EMPTY_MIN_FILL}},
      x_max: {COORD_WIDTH{EMPTY_MAX_FILL}},
      y_min: {COORD_WIDTH{EMPTY_MIN_FILL}},
      y_max: {COORD_WIDTH{EMPTY_MAX_FILL}},
      count: '0
   };

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   entry_t                 tbl_q [NUM_LABELS];
   entry_t                 tbl_d [NUM_LABELS];
   entry_t                 rec_q, rec_d;
   logic [LABEL_WIDTH-1:0] out_label_q, out_label_d;
   logic                   out_valid_q, out_valid_d;
   logic                   frame_done_q, frame_done_d;
   logic                   dropped_q, dropped_d;

   logic                   label_ok;
   logic [IDX_W-1:0]       lbl_idx;
   entry_t                 cur_e;
   entry_t                 merged_e;
   entry_t                 scan_e;
   logic                   drain_step;

   assign label_ok = ({1'b0, label} < LABEL_LIMIT);
   assign lbl_idx  = label[IDX_W-1:0];
   assign cur_e    = tbl_q[lbl_idx];
   assign scan_e   = tbl_q[idx_q];

   bbox_merge #(
      .COORD_WIDTH (COORD_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_merge (
      .x         (x),
      .y         (y),
      .old_x_min (cur_e.x_min),
      .old_x_max (cur_e.x_max),
      .old_y_min (cur_e.y_min),
      .old_y_max (cur_e.y_max),
      .old_count (cur_e.count),
      .new_x_min (merged_e.x_min),
      .new_x_max (merged_e.x_max),
      .new_y_min (merged_e.y_min),
      .new_y_max (merged_e.y_max),
      .new_count (merged_e.count)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      tbl_d        = tbl_q;
      rec_d        = rec_q;
      out_label_d  = out_label_q;
      out_valid_d  = out_valid_q;
      frame_done_d = 1'b0;
      dropped_d    = dropped_q;
      drain_step   = 1'b0;

      if (en && ((state_q != ST_ACCUM) || !label_ok)) begin
         dropped_d = 1'b1;
      end

      case (state_q)
         ST_INIT: begin
            tbl_d[idx_q] = ENTRY_EMPTY;
            if (idx_q == LAST_IDX) begin
               state_d = ST_ACCUM;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_ACCUM: begin
            if (en && label_ok && (label != '0)) begin
               tbl_d[lbl_idx] = merged_e;
            end
            // Entry 0 is background, so the scan starts at 1.
            if (frame_end) begin
               state_d = ST_DRAIN;
               idx_d   = IDX_W'(1);
            end
         end
         ST_DRAIN: begin
            if (out_valid_q) begin
               if (out_ready) begin
                  out_valid_d  = 1'b0;
                  tbl_d[idx_q] = ENTRY_EMPTY;
                  drain_step   = 1'b1;
               end
            end else if (scan_e.count == '0) begin
               drain_step = 1'b1;
            end else begin
               rec_d       = scan_e;
               out_label_d = LABEL_WIDTH'(idx_q);
               out_valid_d = 1'b1;
            end
            if (drain_step) begin
               if (idx_q == LAST_IDX) begin
                  state_d      = ST_ACCUM;
                  idx_d        = '0;
                  frame_done_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_INIT;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_INIT;
         idx_q        <= '0;
         rec_q        <= '0;
         out_label_q  <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         dropped_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         rec_q        <= rec_d;
         out_label_q  <= out_label_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         dropped_q    <= dropped_d;
      end
   end

   // The table needs no reset: INIT rewrites every entry after each reset.
   always_ff @(posedge clk) begin
      tbl_q <= tbl_d;
   end

   assign out_valid  = out_valid_q;
   assign out_label  = out_label_q;
   assign out_x_min  = rec_q.x_min;
   assign out_x_max  = rec_q.x_max;
   assign out_y_min  = rec_q.y_min;
   assign out_y_max  = rec_q.y_max;
   assign out_count  = rec_q.count;
   assign frame_done = frame_done_q;
   assign busy       = (state_q != ST_ACCUM);
   assign dropped    = dropped_q;

endmodule

// File: tb/tb_blob_bbox_extractor.sv
// Directed bench for blob_bbox_extractor: hand-computed records checked against what the drain emits.
module tb_blob_bbox_extractor;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       en;
   logic       frame_end;
   logic [9:0] x;
   logic [9:0] y;
   logic [7:0] label;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_label;
   logic [9:0] out_x_min, out_x_max, out_y_min, out_y_max;
   logic [19:0] out_count;
   logic       frame_done;
   logic       busy;
   logic       dropped;

   typedef struct {
      int lbl;
      int xmin;
      int xmax;
      int ymin;
      int ymax;
      int cnt;
   } rec_t;

   rec_t got_q[$];
   int   vec_cnt = 0;
   int   err_cnt = 0;

   always #5 clk = ~clk;

   blob_bbox_extractor dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .frame_end  (frame_end),
      .x          (x),
      .y          (y),
      .label      (label),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_label  (out_label),
      .out_x_min  (out_x_min),
      .out_x_max  (out_x_max),
      .out_y_min  (out_y_min),
      .out_y_max  (out_y_max),
      .out_count  (out_count),
      .frame_done (frame_done),
      .busy       (busy),
      .dropped    (dropped)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pixel(input int px, input int py, input int lbl);
      en    = 1'b1;
      x     = 10'(px);
      y     = 10'(py);
      label = 8'(lbl);
      step();
      en    = 1'b0;
   endtask

   task automatic end_frame(input bit with_pix, input int px, input int py, input int lbl);
      frame_end = 1'b1;
      if (with_pix) begin
         en    = 1'b1;
         x     = 10'(px);
         y     = 10'(py);
         label = 8'(lbl);
      end
      step();
      frame_end = 1'b0;
      en        = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 300) begin
         step();
         n++;
      end
   endtask

   // Collects every handshaken record until frame_done; returns cycles from entry to frame_done.
   task automatic drain(output int n);
      rec_t r;
      n = 0;
      got_q.delete();
      out_ready = 1'b1;
      while (n < 1000) begin
         if (out_valid && out_ready) begin
            r.lbl  = int'(out_label);
            r.xmin = int'(out_x_min);
            r.xmax = int'(out_x_max);
            r.ymin = int'(out_y_min);
            r.ymax = int'(out_y_max);
            r.cnt  = int'(out_count);
            got_q.push_back(r);
         end
         step();
         n++;
         if (frame_done) break;
      end
      if (!frame_done) check("drain_timeout", 32'(n), 32'd0);
   endtask

   task automatic check_rec(input int i, input int lbl, input int xmin, input int xmax,
                            input int ymin, input int ymax, input int cnt);
      if (got_q.size() <= i) begin
         check("rec_missing", 32'(got_q.size()), 32'(i + 1));
      end else begin
         check("rec_label", 32'(got_q[i].lbl),  32'(lbl));
         check("rec_xmin",  32'(got_q[i].xmin), 32'(xmin));
         check("rec_xmax",  32'(got_q[i].xmax), 32'(xmax));
         check("rec_ymin",  32'(got_q[i].ymin), 32'(ymin));
         check("rec_ymax",  32'(got_q[i].ymax), 32'(ymax));
         check("rec_count", 32'(got_q[i].cnt),  32'(cnt));
      end
   endtask

   initial begin
      int n;
      int unstable;
      bit seen_valid;
      logic [7:0]  h_lbl;
      logic [9:0]  h_x0, h_x1, h_y0, h_y1;
      logic [19:0] h_cnt;

      reset_n   = 1'b0;
      en        = 1'b0;
      frame_end = 1'b0;
      x         = '0;
      y         = '0;
      label     = '0;
      out_ready = 1'b1;
      step();
      step();
      check("rst_busy",       32'(busy),       32'd1);
      check("rst_out_valid",  32'(out_valid),  32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_dropped",    32'(dropped),    32'd0);
      check("rst_out_label",  32'(out_label),  32'd0);
      check("rst_out_count",  32'(out_count),  32'd0);
      check("rst_out_xmin",   32'(out_x_min),  32'd0);
      reset_n = 1'b1;

      wait_idle(n);
      check("init_cycles", 32'(n), 32'd64);

      // Empty frame: scan of labels 1..63, no records.
      end_frame(1'b0, 0, 0, 0);
      check("drain_busy", 32'(busy), 32'd1);
      seen_valid = 1'b0;
      n = 0;
      while (!frame_done && n < 200) begin
         if (out_valid) seen_valid = 1'b1;
         step();
         n++;
      end
      check("empty_done_cycles", 32'(n), 32'd63);
      check("empty_no_valid", 32'(seen_valid), 32'd0);
      step();
      check("done_pulse_width", 32'(frame_done), 32'd0);
      check("idle_after_drain", 32'(busy), 32'd0);

      // Single blob.
      pixel(3, 7, 5);
      pixel(10, 2, 5);
      pixel(4, 9, 5);
      end_frame(1'b0, 0, 0, 0);
      drain(n);
      check("blob5_nrec", 32'(got_q.size()), 32'd1);
      check_rec(0, 5, 3, 10, 2, 9, 3);

      // Two labels drained in index order, then table cleared for the next frame.
      pixel(20, 30, 9);
      pixel(1, 1, 2);
      end_frame(1'b0, 0, 0, 0);
      drain(n);
      check("two_nrec", 32'(got_q.size()), 32'd2);
      check_rec(0, 2, 1, 1, 1, 1, 1);
      check_rec(1, 9, 20, 20, 30, 30, 1);
      pixel(0, 0, 9);
      end_frame(1'b0, 0, 0, 0);
      drain(n);
      check("cleared_nrec", 32'(got_q.size()), 32'd1);
      check_rec(0, 9, 0, 0, 0, 0, 1);

      // Backpressure: record must hold for 10 stalled cycles and be emitted once.
      pixel(5, 6, 12);
      pixel(7, 8, 12);
      out_ready = 1'b0;
      end_frame(1'b0, 0, 0, 0);
      n = 0;
      while (!out_valid && n < 200) begin
         step();
         n++;
      end
      check("stall_valid_seen", 32'(out_valid), 32'd1);
      h_lbl = out_label; h_x0 = out_x_min; h_x1 = out_x_max;
      h_y0 = out_y_min;  h_y1 = out_y_max; h_cnt = out_count;
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!out_valid || out_label !== h_lbl || out_x_min !== h_x0 || out_x_max !== h_x1 ||
             out_y_min !== h_y0 || out_y_max !== h_y1 || out_count !== h_cnt)
            unstable++;
      end
      check("stall_unstable_cycles", 32'(unstable), 32'd0);
      drain(n);
      check("stall_nrec", 32'(got_q.size()), 32'd1);
      check_rec(0, 12, 5, 7, 6, 8, 2);

      // Back-to-back same label plus a pixel coincident with frame_end.
      for (int i = 0; i < 5; i++) pixel(i, 10 + i, 3);
      end_frame(1'b1, 50, 2, 3);
      drain(n);
      check("b2b_nrec", 32'(got_q.size()), 32'd1);
      check_rec(0, 3, 0, 50, 2, 14, 6);

      // Dropped pixels: out-of-range label and a pixel during drain.
      check("dropped_clear", 32'(dropped), 32'd0);
      pixel(1, 1, 70);
      check("dropped_range", 32'(dropped), 32'd1);
      pixel(2, 2, 4);
      end_frame(1'b0, 0, 0, 0);
      pixel(100, 100, 4);
      drain(n);
      check("drop_nrec", 32'(got_q.size()), 32'd1);
      check_rec(0, 4, 2, 2, 2, 2, 1);
      check("dropped_sticky", 32'(dropped), 32'd1);

      // Reset during a stalled record abandons it and re-initialises the table.
      pixel(8, 8, 7);
      out_ready = 1'b0;
      end_frame(1'b0, 0, 0, 0);
      n = 0;
      while (!out_valid && n < 200) begin
         step();
         n++;
      end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_dropped", 32'(dropped), 32'd0);
      check("midrst_busy", 32'(busy), 32'd1);
      wait_idle(n);
      check("midrst_init_cycles", 32'(n), 32'd64);
      end_frame(1'b0, 0, 0, 0);
      drain(n);
      check("midrst_nrec", 32'(got_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
